// File: rtl/idu_decq_pkg.sv
// Shared IDU types: instruction/tag widths, opcode map, decode-table and queue-entry records.
// Pure declarations; no timing or handshake.
package idu_decq_pkg;

  localparam int INSTR_LEN = 32;
  localparam int XLEN      = 32;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef struct packed {
    logic       legal;
    logic       lui;
    logic       auipc;
    logic       jal;
    logic       jalr;
    logic       branch;
    logic       load;
    logic       store;
    logic       alu_imm;
    logic       alu_reg;
    logic       imm12;
    logic       imm20;
    logic       rs1_en;
    logic       rs2_en;
    logic       rd_en;
    logic [2:0] funct3;
    logic       funct7_5;
  } decode_out_t;

  typedef struct packed {
    logic [XLEN-1:0] tag;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [XLEN-1:0] imm;
    logic            imm_valid;
    decode_out_t     dec;
  } idu0_out_t;

endpackage

// File: rtl/idu_decq_if.sv
// IFU -> decode queue -> idu1 handshake bundle; slave is the queue's view, master the surroundings'.
// Carries valid/ready on both sides plus flush and occupancy.
interface idu_decq_if
  import idu_decq_pkg::*;
#(
  parameter int DEPTH = 4
);
  logic [INSTR_LEN-1:0]         instr;
  logic                         instr_valid;
  logic [XLEN-1:0]              instr_tag;
  logic                         instr_ready;
  idu0_out_t                    idu0_out;
  logic                         idu0_valid;
  logic                         idu0_ready;
  logic                         pipe_flush;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;

  modport master (
    output instr, instr_valid, instr_tag, idu0_ready, pipe_flush,
    input  instr_ready, idu0_out, idu0_valid, occupancy
  );

  modport slave (
    input  instr, instr_valid, instr_tag, idu0_ready, pipe_flush,
    output instr_ready, idu0_out, idu0_valid, occupancy
  );
endinterface

// File: rtl/fifo.sv
// Generic count-based FIFO with flush; write-to-read latency 1 cycle, reset clears storage.
// Push ignored when full, pop ignored when empty; flush wins over both and keeps storage.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dat_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointers wrap naturally since DEPTH is a power of two; full/empty come from count only.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= dat_i;
    end
  end

  assign dat_o   = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/idu_dec_table.sv
// RV32I decode table: opcode/funct fields to control bits and legality.
// Purely combinational; no handshake.
module idu_dec_table
  import idu_decq_pkg::*;
(
  input  logic [INSTR_LEN-1:0] instr_i,
  output decode_out_t          dec_o
);
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign f3            = instr_i[14:12];
  assign f7            = instr_i[31:25];
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  // Unknown opcodes fall through with every bit clear, which marks them illegal.
  always_comb begin
    dec_o          = '0;
    dec_o.funct3   = f3;
    dec_o.funct7_5 = instr_i[30];
    case (instr_i[6:0])
      OPC_LUI: begin
        dec_o.legal = 1'b1; dec_o.lui = 1'b1; dec_o.imm20 = 1'b1; dec_o.rd_en = 1'b1;
      end
      OPC_AUIPC: begin
        dec_o.legal = 1'b1; dec_o.auipc = 1'b1; dec_o.imm20 = 1'b1; dec_o.rd_en = 1'b1;
      end
      OPC_JAL: begin
        dec_o.legal = 1'b1; dec_o.jal = 1'b1; dec_o.imm20 = 1'b1; dec_o.rd_en = 1'b1;
      end
      OPC_JALR: begin
        dec_o.legal = (f3 == 3'd0);
        dec_o.jalr = 1'b1; dec_o.imm12 = 1'b1; dec_o.rs1_en = 1'b1; dec_o.rd_en = 1'b1;
      end
      OPC_BRANCH: begin
        dec_o.legal  = (f3 != 3'd2) && (f3 != 3'd3);
        dec_o.branch = 1'b1; dec_o.rs1_en = 1'b1; dec_o.rs2_en = 1'b1;
      end
      OPC_LOAD: begin
        dec_o.legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        dec_o.load  = 1'b1; dec_o.rs1_en = 1'b1; dec_o.rd_en = 1'b1;
      end
      OPC_STORE: begin
        dec_o.legal = (f3 < 3'd3);
        dec_o.store = 1'b1; dec_o.rs1_en = 1'b1; dec_o.rs2_en = 1'b1;
      end
      OPC_OPIMM: begin
        if (f3 == 3'd1)      dec_o.legal = (f7 == 7'h00);
        else if (f3 == 3'd5) dec_o.legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                 dec_o.legal = 1'b1;
        dec_o.alu_imm = 1'b1; dec_o.imm12 = 1'b1; dec_o.rs1_en = 1'b1; dec_o.rd_en = 1'b1;
      end
      OPC_OP: begin
        dec_o.legal   = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
        dec_o.alu_reg = 1'b1; dec_o.rs1_en = 1'b1; dec_o.rs2_en = 1'b1; dec_o.rd_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/idu_immgen.sv
// Sign-extended immediate selection (U/J/B/S/I forms) and imm_valid from the decode bits.
// Purely combinational; no handshake.
module idu_immgen
  import idu_decq_pkg::*;
(
  input  logic [INSTR_LEN-1:0] instr_i,
  input  decode_out_t          dec_i,
  output logic [XLEN-1:0]      imm_o,
  output logic                 imm_valid_o
);
  logic unused_dec;

  assign unused_dec = ^{instr_i[6:0], dec_i};

  always_comb begin
    imm_o = '0;
    if (dec_i.imm20 && !dec_i.jal)
      imm_o = {instr_i[31:12], 12'b0};
    else if (dec_i.jal)
      imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    else if (dec_i.branch)
      imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    else if (dec_i.store)
      imm_o = {{21{instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
    else if (dec_i.imm12 || dec_i.load)
      imm_o = {{21{instr_i[31]}}, instr_i[30:20]};
  end

  // Jump/branch offsets are consumed as targets, not as operand immediates.
  assign imm_valid_o = (dec_i.imm20 & ~dec_i.jal) | dec_i.imm12 | dec_i.load | dec_i.store;

endmodule

// File: rtl/idu_decq.sv
// Decode-on-entry queue between IFU and idu1; accept-to-head 1 cycle, 1 instr/cycle sustained.
// instr_ready = not full (independent of idu0_ready); flush empties in one cycle. IDU_DECQ_PERF_EN adds hwm/stall_cnt.
module idu_decq
  import idu_decq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  idu_decq_if.slave                  bus
`ifdef IDU_DECQ_PERF_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] hwm,
  output logic [31:0]                stall_cnt
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = $bits(idu0_out_t);

  decode_out_t     dec;
  logic [XLEN-1:0] imm;
  logic            imm_valid;
  idu0_out_t       entry;
  logic [EW-1:0]   head;
  logic            full, empty;
  logic [CW-1:0]   count;

  idu_dec_table u_dec (
    .instr_i (bus.instr),
    .dec_o   (dec)
  );

  idu_immgen u_immgen (
    .instr_i     (bus.instr),
    .dec_i       (dec),
    .imm_o       (imm),
    .imm_valid_o (imm_valid)
  );

  always_comb begin
    entry           = '0;
    entry.tag       = bus.instr_tag;
    entry.rs1       = bus.instr[19:15];
    entry.rs2       = bus.instr[24:20];
    entry.rd        = bus.instr[11:7];
    entry.shamt     = bus.instr[24:20];
    entry.imm       = imm;
    entry.imm_valid = imm_valid;
    entry.dec       = dec;
  end

  fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.pipe_flush),
    .push_i  (bus.instr_valid),
    .dat_i   (entry),
    .pop_i   (bus.idu0_ready),
    .dat_o   (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign bus.instr_ready = ~full;
  assign bus.idu0_valid  = ~empty;
  assign bus.idu0_out    = idu0_out_t'(head);
  assign bus.occupancy   = count;

`ifdef IDU_DECQ_PERF_EN
  logic [CW-1:0] hwm_q, hwm_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  // Counters survive flush; only reset clears them.
  always_comb begin
    hwm_d       = (count > hwm_q) ? count : hwm_q;
    stall_cnt_d = stall_cnt_q;
    if (bus.instr_valid && full && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      hwm_q       <= hwm_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hwm       = hwm_d;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_idu_decq.sv
// Bench for idu_decq: directed phases plus random traffic against a queue-of-records model.
// Perf counter checks are compiled in when IDU_DECQ_PERF_EN is defined.
module tb_idu_decq;
  import idu_decq_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  idu_decq_if #(.DEPTH(DEPTH)) bus ();

`ifdef IDU_DECQ_PERF_EN
  logic [CW-1:0] hwm;
  logic [31:0]   stall_cnt;
`endif

  idu_decq #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IDU_DECQ_PERF_EN
    ,
    .hwm       (hwm),
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] tag;
    logic [31:0] imm;
    logic        iv;
    logic        legal;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   last_push;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   m_hwm    = 0;
  int   m_stall  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Build an instruction from chosen fields and state its expected decode directly from those fields.
  task automatic gen(input int kind, input logic [31:0] tag, output logic [31:0] ins, output exp_t e);
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] i12;
    logic [19:0] i20;
    logic [20:0] j21;
    logic [24:0] junk;
    rd   = 5'($urandom);
    rs1  = 5'($urandom);
    rs2  = 5'($urandom);
    i12  = 12'($urandom);
    i20  = 20'($urandom);
    j21  = 21'($urandom) & ~21'd1;
    junk = 25'($urandom);
    e.tag   = tag;
    e.legal = 1'b1;
    e.rd    = rd;
    case (kind)
      0: begin
        ins = {i12, rs1, 3'b000, rd, 7'h13};
        e.imm = int'($signed(i12)); e.iv = 1'b1;
      end
      1: begin
        ins = {i20, rd, 7'h37};
        e.imm = {i20, 12'h000}; e.iv = 1'b1;
      end
      2: begin
        ins = {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'h6f};
        e.imm = int'($signed(j21)); e.iv = 1'b0;
      end
      3: begin
        ins = {i12[11:5], rs2, rs1, 3'b010, i12[4:0], 7'h23};
        e.imm = int'($signed(i12)); e.iv = 1'b1; e.rd = i12[4:0];
      end
      default: begin
        ins = {junk, 7'h7f};
        e.imm = 32'h0; e.iv = 1'b0; e.legal = 1'b0; e.rd = junk[4:0];
      end
    endcase
  endtask

  task automatic offer(input int kind, input logic [31:0] tag);
    logic [31:0] ins;
    gen(kind, tag, ins, cur);
    bus.instr       = ins;
    bus.instr_tag   = tag;
    bus.instr_valid = 1'b1;
  endtask

  // Check outputs against the model, then advance one clock and update the model.
  task automatic cycle();
    int sz;
    bit push, pop, flush;
    sz = q.size();
    chk("instr_ready", 128'(bus.instr_ready), 128'(sz != DEPTH));
    chk("idu0_valid", 128'(bus.idu0_valid), 128'(sz != 0));
    chk("occupancy", 128'(bus.occupancy), 128'(sz));
    if (sz != 0) begin
      chk("head_tag", 128'(bus.idu0_out.tag), 128'(q[0].tag));
      chk("head_imm", 128'(bus.idu0_out.imm), 128'(q[0].imm));
      chk("head_imm_valid", 128'(bus.idu0_out.imm_valid), 128'(q[0].iv));
      chk("head_legal", 128'(bus.idu0_out.dec.legal), 128'(q[0].legal));
      chk("head_rd", 128'(bus.idu0_out.rd), 128'(q[0].rd));
    end
`ifdef IDU_DECQ_PERF_EN
    if (sz > m_hwm) m_hwm = sz;
    chk("hwm", 128'(hwm), 128'(m_hwm));
    chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
`endif
    push  = bus.instr_valid && (sz != DEPTH);
    pop   = bus.idu0_ready && (sz != 0);
    flush = bus.pipe_flush;
    if (bus.instr_valid && sz == DEPTH) m_stall++;
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(cur);
    end
    last_push = push && !flush;
  endtask

  initial begin
    int i, k;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.instr_tag   = '0;
    bus.idu0_ready  = 1'b0;
    bus.pipe_flush  = 1'b0;
    cur             = '{default: '0};
    last_push       = 1'b0;
    rst_n           = 1'b0;
    #11;
    chk("rst_instr_ready", 128'(bus.instr_ready), 128'(1));
    chk("rst_idu0_valid", 128'(bus.idu0_valid), 128'(0));
    chk("rst_occupancy", 128'(bus.occupancy), 128'(0));
    chk("rst_idu0_out", 128'(bus.idu0_out), 128'(0));
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decode spot checks with hand-derived expectations.
    bus.instr = 32'hFFF1_0093; bus.instr_tag = 32'h100; bus.instr_valid = 1'b1;
    cur = '{tag: 32'h100, imm: 32'hFFFF_FFFF, iv: 1'b1, legal: 1'b1, rd: 5'd1};
    cycle();
    bus.instr = 32'hFFDF_F06F; bus.instr_tag = 32'h104; bus.idu0_ready = 1'b1;
    cur = '{tag: 32'h104, imm: 32'hFFFF_FFFC, iv: 1'b0, legal: 1'b1, rd: 5'd0};
    cycle();
    bus.instr_valid = 1'b0;
    cycle();
    cycle();

    // Fill with idu1 stalled, then drain in order.
    bus.idu0_ready = 1'b0;
    i = 0;
    for (int c = 0; c < 10 && i < 5; c++) begin
      offer(0, 32'hA0 + 32'(i));
      cycle();
      if (last_push) i++;
    end
    chk("fill_ready", 128'(bus.instr_ready), 128'(0));
    chk("fill_occupancy", 128'(bus.occupancy), 128'(4));
    bus.idu0_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.idu0_valid) begin
        chk("drain_tag", 128'(bus.idu0_out.tag), 128'(32'hA0 + 32'(k)));
        k++;
      end
      cycle();
      if (last_push) bus.instr_valid = 1'b0;
    end
    chk("drain_count", 128'(k), 128'(5));

    // Streaming: one in, one out every cycle.
    for (int n = 0; n < 20; n++) begin
      offer(int'($urandom_range(0, 4)), 32'h200 + 32'(n));
      cycle();
      chk("stream_occupancy", 128'(bus.occupancy), 128'(1));
      chk("stream_tag", 128'(bus.idu0_out.tag), 128'(32'h200 + 32'(n)));
    end
    bus.instr_valid = 1'b0;
    cycle();

    // Random traffic with occasional flush.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) != 0) offer(int'($urandom_range(0, 4)), 32'h1000 + 32'(n));
      else bus.instr_valid = 1'b0;
      bus.idu0_ready = ($urandom_range(0, 1) != 0);
      bus.pipe_flush = ($urandom_range(0, 24) == 0);
      cycle();
    end
    bus.pipe_flush  = 1'b0;
    bus.instr_valid = 1'b0;
    bus.idu0_ready  = 1'b1;
    for (int n = 0; n < 6; n++) cycle();

    // Asynchronous reset between clock edges with two entries queued.
    bus.idu0_ready = 1'b0;
    offer(1, 32'h300); cycle();
    offer(3, 32'h304); cycle();
    bus.instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_idu0_valid", 128'(bus.idu0_valid), 128'(0));
    chk("arst_idu0_out", 128'(bus.idu0_out), 128'(0));
    chk("arst_instr_ready", 128'(bus.instr_ready), 128'(1));
    chk("arst_occupancy", 128'(bus.occupancy), 128'(0));
`ifdef IDU_DECQ_PERF_EN
    chk("arst_hwm", 128'(hwm), 128'(0));
    chk("arst_stall_cnt", 128'(stall_cnt), 128'(0));
`endif
    q.delete();
    m_hwm   = 0;
    m_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Flush with three queued plus a simultaneous push.
    for (int n = 0; n < 3; n++) begin
      offer(0, 32'h400 + 32'(n));
      cycle();
    end
    offer(0, 32'hBAD);
    bus.pipe_flush = 1'b1;
    cycle();
    bus.pipe_flush  = 1'b0;
    bus.instr_valid = 1'b0;
    chk("flush_idu0_valid", 128'(bus.idu0_valid), 128'(0));
    chk("flush_occupancy", 128'(bus.occupancy), 128'(0));
    chk("flush_instr_ready", 128'(bus.instr_ready), 128'(1));
    bus.idu0_ready = 1'b1;
    cycle();
    cycle();
`ifdef IDU_DECQ_PERF_EN
    chk("flush_hwm_kept", 128'(hwm), 128'(3));
`endif

    // Fill, then hold IFU blocked for seven cycles.
    bus.idu0_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      offer(2, 32'h500 + 32'(n));
      cycle();
    end
    for (int n = 0; n < 7; n++) begin
      offer(4, 32'h5FF);
      cycle();
    end
    bus.instr_valid = 1'b0;
    cycle();
`ifdef IDU_DECQ_PERF_EN
    chk("perf_stall_cnt", 128'(stall_cnt), 128'(7));
`endif
    bus.idu0_ready = 1'b1;
    for (int n = 0; n < 6; n++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
